// File: rtl/iobus_arbiter.sv
// Two-requester iobus arbiter: CPU memory stage (req 0) and debug loader (req 1).
// Define IOARB_FAIRNESS_EN to add a starvation counter that periodically forces a debug grant.
module iobus_arbiter #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
`ifdef IOARB_FAIRNESS_EN
  , parameter int unsigned STARVE_LIMIT = 4
`endif
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wrdata,
  output logic              cpu_stall,
  output logic [DATA_W-1:0] cpu_rddata,
  output logic              cpu_rdvalid,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wrdata,
  output logic              dbg_gnt,
  output logic [DATA_W-1:0] dbg_rddata,
  output logic              dbg_rdvalid,
  output logic              bus_rdstrobe,
  output logic              bus_wrstrobe,
  output logic [ADDR_W-1:0] bus_address,
  output logic [DATA_W-1:0] bus_wrdata,
  input  logic [DATA_W-1:0] bus_rddata
);

  logic cpu_gnt_c;
  logic dbg_gnt_c;
  logic force_dbg_c;
  logic sel_we_c;
  logic rd_pend_q, rd_pend_d;
  logic rd_owner_q, rd_owner_d;

`ifdef IOARB_FAIRNESS_EN
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_q, starve_d;
  logic             force_dbg_q, force_dbg_d;

  assign force_dbg_c = force_dbg_q;

  // Count denied debug cycles; at the limit arm a one-shot forced debug win.
  always_comb begin
    starve_d    = starve_q;
    force_dbg_d = force_dbg_q;
    if (!dbg_req || dbg_gnt_c) begin
      starve_d    = '0;
      force_dbg_d = 1'b0;
    end else if (starve_q == LIMIT) begin
      force_dbg_d = 1'b1;
    end else begin
      starve_d = starve_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      starve_q    <= '0;
      force_dbg_q <= 1'b0;
    end else begin
      starve_q    <= starve_d;
      force_dbg_q <= force_dbg_d;
    end
  end
`else
  assign force_dbg_c = 1'b0;
`endif

  // CPU has priority unless the fairness logic forces a debug win.
  always_comb begin
    dbg_gnt_c = dbg_req & (~cpu_req | force_dbg_c);
    cpu_gnt_c = cpu_req & ~dbg_gnt_c;
  end

  // Granted requester drives the bus; strobes are mutually exclusive by construction.
  always_comb begin
    sel_we_c    = 1'b0;
    bus_address = '0;
    bus_wrdata  = '0;
    if (cpu_gnt_c) begin
      sel_we_c    = cpu_we;
      bus_address = cpu_addr;
      bus_wrdata  = cpu_wrdata;
    end else if (dbg_gnt_c) begin
      sel_we_c    = dbg_we;
      bus_address = dbg_addr;
      bus_wrdata  = dbg_wrdata;
    end
    bus_wrstrobe = (cpu_gnt_c | dbg_gnt_c) & sel_we_c;
    bus_rdstrobe = (cpu_gnt_c | dbg_gnt_c) & ~sel_we_c;
  end

  assign cpu_stall = cpu_req & ~cpu_gnt_c;
  assign dbg_gnt   = dbg_gnt_c;

  // Remember who issued this cycle's read so next cycle's data is steered back.
  always_comb begin
    rd_pend_d  = bus_rdstrobe;
    rd_owner_d = bus_rdstrobe ? dbg_gnt_c : rd_owner_q;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      rd_pend_q  <= 1'b0;
      rd_owner_q <= 1'b0;
    end else begin
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  assign cpu_rdvalid = rd_pend_q & ~rd_owner_q;
  assign dbg_rdvalid = rd_pend_q & rd_owner_q;
  assign cpu_rddata  = bus_rddata;
  assign dbg_rddata  = bus_rddata;

endmodule
